// File: rtl/lpc2mem_ring_if.sv
// Bus bundle between the LPC decoder, the ring writer and the capture RAM write port.
// The slave side is the ring writer; the master side drives LPC frames and observes RAM writes.
interface lpc2mem_ring_if #(
    parameter int unsigned SLOT_BITS = 5
);
    logic [3:0]           lpc_cyctype_dir;
    logic [31:0]          lpc_addr;
    logic [7:0]           lpc_data;
    logic                 lpc_latch;
    logic [SLOT_BITS+2:0] ram_addr;
    logic [7:0]           ram_data;
    logic                 ram_we;

    modport master (
        output lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch,
        input  ram_addr, ram_data, ram_we
    );

    modport slave (
        input  lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch,
        output ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/lpc2mem_ring.sv
// Queues captured LPC frames and writes each as an 8-byte record into a RAM ring buffer,
// tagging it with a sequence number, the drop count and an XOR checksum.
module lpc2mem_ring #(
    parameter int unsigned SLOT_BITS = 5,
    parameter int unsigned INQ_BITS  = 1,  // must be >= 1
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    lpc2mem_ring_if.slave        bus,
    input  logic [SLOT_BITS-1:0] rd_slot,
    input  logic                 drop_clr,
    output logic [SLOT_BITS-1:0] wr_slot,
    output logic                 frame_done,
    output logic                 ring_full,
    output logic                 ring_empty,
    output logic [7:0]           drop_count
);
    localparam int unsigned          Depth       = 1 << INQ_BITS;
    localparam logic [INQ_BITS:0]    PtrOne      = (INQ_BITS+1)'(1);
    localparam logic [INQ_BITS:0]    DepthCnt    = (INQ_BITS+1)'(Depth);
    localparam logic [SLOT_BITS-1:0] SlotOne     = SLOT_BITS'(1);
    localparam bit                   OverwriteEn = (OVERWRITE != 0);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e               state_q, state_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d;
    logic [3:0]           seq_q, seq_d;
    logic [63:0]          rec_q, rec_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           drop_count_q;
    logic                 latch_q;

    logic [43:0]          queue_q [Depth];
    logic [INQ_BITS:0]    qwr_q, qrd_q;
    logic [INQ_BITS:0]    q_count;
    logic                 q_empty, q_full;
    logic                 push, pop, accept, drop;

    logic [43:0]          head;
    logic [7:0]           b0, chk;
    logic [63:0]          rec_new, rec_shift;

    assign ring_full  = (wr_slot_q + SlotOne) == rd_slot;
    assign ring_empty = wr_slot_q == rd_slot;

    assign q_count = qwr_q - qrd_q;
    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == DepthCnt);

    assign push   = bus.lpc_latch && !latch_q;
    assign pop    = (state_q == StIdle) && !q_empty && (OverwriteEn || !ring_full);
    // A pop in the same cycle frees the slot, so a push into a full queue still fits.
    assign accept = push && (!q_full || pop);
    assign drop   = push && !accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latch_q <= 1'b0;
            qwr_q   <= '0;
            qrd_q   <= '0;
        end else begin
            latch_q <= bus.lpc_latch;
            if (accept) qwr_q <= qwr_q + PtrOne;
            if (pop)    qrd_q <= qrd_q + PtrOne;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            queue_q[qwr_q[INQ_BITS-1:0]] <= {bus.lpc_cyctype_dir, bus.lpc_addr, bus.lpc_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count_q <= 8'd0;
        end else if (drop_clr) begin
            drop_count_q <= 8'd0;
        end else if (drop && drop_count_q != 8'hff) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign head    = queue_q[qrd_q[INQ_BITS-1:0]];
    assign b0      = {seq_q, head[43:40]};
    assign chk     = b0 ^ head[39:32] ^ head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0]
                     ^ drop_count_q;
    assign rec_new = {b0, head[39:0], drop_count_q, chk};

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        wr_slot_d    = wr_slot_q;
        seq_d        = seq_q;
        rec_d        = rec_q;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d    = StWrite;
                    byte_idx_d = 3'd0;
                    rec_d      = rec_new;
                end
            end
            StWrite: begin
                if (byte_idx_q == 3'd7) begin
                    state_d      = StIdle;
                    byte_idx_d   = 3'd0;
                    wr_slot_d    = wr_slot_q + SlotOne;
                    seq_d        = seq_q + 4'd1;
                    frame_done_d = 1'b1;
                end else begin
                    byte_idx_d = byte_idx_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            byte_idx_q   <= 3'd0;
            wr_slot_q    <= '0;
            seq_q        <= 4'd0;
            rec_q        <= 64'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            wr_slot_q    <= wr_slot_d;
            seq_q        <= seq_d;
            rec_q        <= rec_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Byte 0 sits in the top of rec_q; shift the selected byte up to [63:56].
    assign rec_shift    = rec_q << {byte_idx_q, 3'b000};
    assign bus.ram_we   = (state_q == StWrite);
    assign bus.ram_addr = {wr_slot_q, byte_idx_q};
    assign bus.ram_data = (state_q == StWrite) ? rec_shift[63:56] : 8'd0;

    assign wr_slot    = wr_slot_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_count_q;
endmodule
